hs_rx_fifo: RTL and testbench

Synchronous receive stage that sits directly downstream of the bundled-data pipeline controller's right-hand channel. It consumes the 4-phase Rreq/Rack handshake and its bundled data word, and synchronises Rreq into the local clock domain. Each word is buffered in a small FIFO and presented to clocked logic as a valid/ready stream. It also keeps a free-running count of completed handshakes for throughput measurement.

---
 rtl/hs_pkg.sv | 11 +
 rtl/sync_ff.sv | 23 ++
 rtl/hs_rx_fifo.sv | 111 +++++++++++
 tb/tb_hs_rx_fifo.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared definitions for the 4-phase receive handshake blocks.
package hs_pkg;

  localparam int HS_COUNT_W = 16;

  typedef enum logic {
    WAIT_REQ = 1'b0,
    ACK      = 1'b1
  } hs_state_e;

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser for bringing an asynchronous level into clk.
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d};
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/hs_rx_fifo.sv
// Receive stage: 4-phase Rreq/Rack handshake into a first-word fall-through FIFO
// presented as a valid/ready stream, with a completed-handshake counter.
module hs_rx_fifo
  import hs_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Rreq,
  input  logic [WIDTH-1:0]        Rdata,
  output logic                    Rack,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic [HS_COUNT_W-1:0]   hs_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic                  req_s;
  hs_state_e             state;
  logic                  rack_q;
  logic [HS_COUNT_W-1:0] hs_cnt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level_q;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic                  full;
  logic                  empty;
  logic                  wr_en;
  logic                  rd_en;

  // Request crossing into clk
  sync_ff #(
    .N (SYNC_STAGES)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (Rreq),
    .q   (req_s)
  );

  // Full uses the pre-edge level, so a same-cycle read never frees a slot for this write.
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign wr_en = (state == WAIT_REQ) && req_s && !full;
  assign rd_en = !empty && out_ready;

  // Handshake FSM: one write per 4-phase cycle, Rack registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= WAIT_REQ;
      rack_q <= 1'b0;
      wr_ptr <= '0;
      hs_cnt <= '0;
    end else begin
      case (state)
        WAIT_REQ: begin
          if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            rack_q <= 1'b1;
            state  <= ACK;
          end
        end
        ACK: begin
          if (!req_s) begin
            rack_q <= 1'b0;
            hs_cnt <= hs_cnt + HS_COUNT_W'(1);
            state  <= WAIT_REQ;
          end
        end
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= Rdata;
    end
  end

  // Read side and occupancy counter
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign Rack      = rack_q;
  assign out_data  = mem[rd_ptr];
  assign out_valid = !empty;
  assign level     = level_q;
  assign hs_count  = hs_cnt;

endmodule

// File: tb/tb_hs_rx_fifo.sv
// Scoreboard bench for hs_rx_fifo: handshake latency, backpressure, ordering, reset and wrap.
module tb_hs_rx_fifo;
  import hs_pkg::*;

  localparam int WIDTH       = 8;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int LVL_W       = $clog2(DEPTH) + 1;
  localparam int HS_LAT      = SYNC_STAGES + 1;

  logic                  clk;
  logic                  rst;
  logic                  Rreq;
  logic [WIDTH-1:0]      Rdata;
  logic                  Rack;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [LVL_W-1:0]      level;
  logic [HS_COUNT_W-1:0] hs_count;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [WIDTH-1:0] sb [$];
  int               max_lvl  = 0;
  int               exp_hs   = 0;

  hs_rx_fifo #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Rreq      (Rreq),
    .Rdata     (Rdata),
    .Rack      (Rack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .hs_count  (hs_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Consumer side: every accepted word must be the oldest one driven in.
  always @(negedge clk) begin
    if (!rst) begin
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("rd_data", 32'(out_data), 32'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rack(input logic val, output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (Rack !== val && edges < 40);
  endtask

  task automatic handshake(input logic [WIDTH-1:0] d, output int up, output int dn);
    Rdata = d;
    sb.push_back(d);
    Rreq = 1'b1;
    wait_rack(1'b1, up);
    Rreq = 1'b0;
    wait_rack(1'b0, dn);
    exp_hs++;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) tick();
    repeat (3) tick();
    out_ready = 1'b0;
    check({tag, "_lvl"}, 32'(level), 32'd0);
    check({tag, "_sb"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int up, dn, cnt;
    logic [WIDTH-1:0] d;

    rst       = 1'b1;
    Rreq      = 1'b0;
    Rdata     = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_rack", 32'(Rack), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_hs", 32'(hs_count), 32'd0);

    // Single word
    Rdata = 8'hA5;
    sb.push_back(8'hA5);
    Rreq = 1'b1;
    wait_rack(1'b1, up);
    check("single_up", 32'(up), 32'(HS_LAT));
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'hA5);
    check("single_lvl", 32'(level), 32'd1);
    Rreq = 1'b0;
    wait_rack(1'b0, dn);
    exp_hs++;
    check("single_dn", 32'(dn), 32'(HS_LAT));
    check("single_hs", 32'(hs_count), 32'(exp_hs));
    drain("single_drain");

    // Fill to full, then backpressure on word 5
    for (int i = 1; i <= DEPTH; i++) begin
      handshake(WIDTH'(i), up, dn);
      check("fill_up", 32'(up), 32'(HS_LAT));
    end
    check("fill_lvl", 32'(level), 32'(DEPTH));
    Rdata = 8'h05;
    sb.push_back(8'h05);
    Rreq = 1'b1;
    repeat (10) tick();
    check("full_rack", 32'(Rack), 32'd0);
    check("full_lvl", 32'(level), 32'(DEPTH));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("full_same_edge_rack", 32'(Rack), 32'd0);
    check("full_after_rd_lvl", 32'(level), 32'(DEPTH - 1));
    tick();
    check("full_capture_rack", 32'(Rack), 32'd1);
    check("full_capture_lvl", 32'(level), 32'(DEPTH));
    Rreq = 1'b0;
    wait_rack(1'b0, dn);
    exp_hs++;
    check("full_dn", 32'(dn), 32'(HS_LAT));
    drain("fill_drain");
    check("fill_hs", 32'(hs_count), 32'(exp_hs));

    // Concurrent flow
    out_ready = 1'b1;
    max_lvl   = 0;
    for (int i = 0; i < 20; i++) begin
      d = WIDTH'($urandom_range(0, 255));
      handshake(d, up, dn);
      check("flow_up", 32'(up), 32'(HS_LAT));
    end
    repeat (3) tick();
    check("flow_maxlvl", 32'(max_lvl), 32'd1);
    check("flow_sb", 32'(sb.size()), 32'd0);
    check("flow_hs", 32'(hs_count), 32'(exp_hs));
    out_ready = 1'b0;

    // Long request: one write only
    Rdata = 8'h77;
    sb.push_back(8'h77);
    Rreq = 1'b1;
    wait_rack(1'b1, up);
    cnt = 0;
    repeat (50) begin
      tick();
      if (Rack === 1'b1) cnt++;
    end
    check("long_rack_cycles", 32'(cnt), 32'd50);
    check("long_lvl", 32'(level), 32'd1);
    Rreq = 1'b0;
    wait_rack(1'b0, dn);
    exp_hs++;
    check("long_hs", 32'(hs_count), 32'(exp_hs));
    drain("long_drain");

    // Reset while in ACK with Rreq still high
    Rdata = 8'h3C;
    sb.push_back(8'h3C);
    Rreq = 1'b1;
    wait_rack(1'b1, up);
    check("rack_pre_rst", 32'(Rack), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_rack", 32'(Rack), 32'd0);
    check("midrst_lvl", 32'(level), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_hs", 32'(hs_count), 32'd0);
    exp_hs = 0;
    sb.delete();
    sb.push_back(8'h3C);
    wait_rack(1'b1, up);
    check("midrst_recap_up", 32'(up), 32'(HS_LAT));
    check("midrst_recap_lvl", 32'(level), 32'd1);
    Rreq = 1'b0;
    wait_rack(1'b0, dn);
    exp_hs++;
    check("midrst_recap_hs", 32'(hs_count), 32'(exp_hs));
    drain("midrst_drain");

    // hs_count wrap
    force dut.hs_cnt = 16'hFFFF;
    tick();
    release dut.hs_cnt;
    tick();
    check("wrap_pre", 32'(hs_count), 32'hFFFF);
    handshake(8'h99, up, dn);
    check("wrap_post", 32'(hs_count), 32'h0000);
    drain("wrap_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
